halt_dump_controller: RTL and testbench

- Synthesizable successor to the bench-only run/halt/dump logic around `machine`.
- Streams a per-cycle PC trace, detects end of program, freezes the CPU, then streams a register-file and data-memory dump over one valid/ready channel.
- Sits beside `machine`. It drives `machine`'s stall input and borrows the debug read ports of `rf` and `data_memory`.
- All counts, windows and the trace mode are parameters.

---
 rtl/dbg_pkg.sv | 20 ++
 rtl/stream_out_reg.sv | 40 ++++
 rtl/halt_dump_controller.sv | 142 ++++++++++++++
 tb/tb_halt_dump_controller.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_pkg.sv
// Shared states, stream tags and halt causes for the run/halt/dump controller.
package dbg_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DUMP_REG,
    S_DUMP_MEM,
    S_END,
    S_DONE
  } state_e;

  localparam logic [1:0] TAG_PC  = 2'd0;
  localparam logic [1:0] TAG_REG = 2'd1;
  localparam logic [1:0] TAG_MEM = 2'd2;
  localparam logic [1:0] TAG_END = 2'd3;

  localparam logic [1:0] CAUSE_NONE      = 2'd0;
  localparam logic [1:0] CAUSE_ZERO_INST = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT   = 2'd2;
endpackage

// File: rtl/stream_out_reg.sv
// Single-entry valid/ready output stage: a record refused by the consumer is
// captured and replayed unchanged until accepted; fire marks each handshake.
module stream_out_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [1:0]        in_tag,
  input  logic [DATA_W-1:0] in_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [1:0]        out_tag,
  output logic [DATA_W-1:0] out_data,
  output logic              fire
);
  logic              held;
  logic [1:0]        h_tag;
  logic [DATA_W-1:0] h_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      held   <= 1'b0;
      h_tag  <= 2'd0;
      h_data <= '0;
    end else if (out_ready) begin
      held <= 1'b0;
    end else if (in_valid && !held) begin
      held   <= 1'b1;
      h_tag  <= in_tag;
      h_data <= in_data;
    end
  end

  // Idle outputs read as zero so the stream is quiet outside a record.
  assign out_valid = held | in_valid;
  assign out_tag   = held ? h_tag  : (in_valid ? in_tag  : 2'd0);
  assign out_data  = held ? h_data : (in_valid ? in_data : '0);
  assign fire      = out_valid & out_ready;
endmodule

// File: rtl/halt_dump_controller.sv
// Runs the CPU with an optional PC trace, halts on a zero instruction or
// timeout, then streams the register file, a memory window and an END record.
module halt_dump_controller
  import dbg_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter int                NUM_REGS   = 32,
  parameter logic [ADDR_W-1:0] MEM_BASE   = 'h4000,
  parameter int                MEM_WORDS  = 4,
  parameter int                MAX_CYCLES = 64,
  parameter bit                TRACE_EN   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] pc,
  input  logic [DATA_W-1:0] inst,
  output logic              cpu_stall,
  output logic [4:0]        rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_tag,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        halt_cause,
  output logic              busy,
  output logic              done
);
  localparam logic [4:0]        REG_LAST = 5'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] MEM_LAST = MEM_BASE + ADDR_W'(MEM_WORDS) - ADDR_W'(1);
  localparam logic [31:0]       CNT_LAST = 32'(MAX_CYCLES - 1);

  state_e            state, state_nxt;
  logic [31:0]       cnt, cnt_nxt;
  logic [1:0]        cause_nxt;
  logic [4:0]        rf_nxt;
  logic [ADDR_W-1:0] mem_nxt;
  logic              rec_valid, fire, exec;
  logic [1:0]        rec_tag;
  logic [DATA_W-1:0] rec_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      halt_cause <= CAUSE_NONE;
      rf_raddr   <= '0;
      mem_raddr  <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      halt_cause <= cause_nxt;
      rf_raddr   <= rf_nxt;
      mem_raddr  <= mem_nxt;
    end
  end

  // Record source: the rf/mem read index only moves on a handshake, so the
  // combinational read data is stable for as long as the record is offered.
  always_comb begin
    rec_valid = 1'b0;
    rec_tag   = TAG_PC;
    rec_data  = '0;
    unique case (state)
      S_RUN:      begin rec_valid = TRACE_EN; rec_data = DATA_W'(pc); end
      S_DUMP_REG: begin rec_valid = 1'b1; rec_tag = TAG_REG; rec_data = rf_rdata; end
      S_DUMP_MEM: begin rec_valid = 1'b1; rec_tag = TAG_MEM; rec_data = mem_rdata; end
      S_END:      begin rec_valid = 1'b1; rec_tag = TAG_END; rec_data = DATA_W'(halt_cause); end
      default:    ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cause_nxt = halt_cause;
    rf_nxt    = rf_raddr;
    mem_nxt   = mem_raddr;
    cpu_stall = 1'b1;
    exec      = TRACE_EN ? fire : 1'b1;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt = S_RUN;
          cnt_nxt   = '0;
          cause_nxt = CAUSE_NONE;
        end
      end
      S_RUN: begin
        cpu_stall = !exec;
        if (exec) begin
          cnt_nxt = cnt + 32'd1;
          if (inst == '0 || cnt == CNT_LAST) begin
            cause_nxt = (inst == '0) ? CAUSE_ZERO_INST : CAUSE_TIMEOUT;
            state_nxt = S_DUMP_REG;
            rf_nxt    = '0;
          end
        end
      end
      S_DUMP_REG: begin
        if (fire) begin
          if (rf_raddr == REG_LAST) begin
            state_nxt = (MEM_WORDS == 0) ? S_END : S_DUMP_MEM;
            mem_nxt   = MEM_BASE;
          end else begin
            rf_nxt = rf_raddr + 5'd1;
          end
        end
      end
      S_DUMP_MEM: begin
        if (fire) begin
          if (mem_raddr == MEM_LAST) state_nxt = S_END;
          else                       mem_nxt   = mem_raddr + ADDR_W'(1);
        end
      end
      S_END: begin
        if (fire) state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  stream_out_reg #(.DATA_W(DATA_W)) u_out (
    .clk      (clk),
    .reset    (reset),
    .in_valid (rec_valid),
    .in_tag   (rec_tag),
    .in_data  (rec_data),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_tag  (out_tag),
    .out_data (out_data),
    .fire     (fire)
  );

  assign busy = (state == S_RUN) || (state == S_DUMP_REG) ||
                (state == S_DUMP_MEM) || (state == S_END);
  assign done = (state == S_DONE);
endmodule

// File: tb/tb_halt_dump_controller.sv
// Randomized bench: a CPU/rf/mem model feeds two controller configurations and
// captured stream records are compared with a list derived from the halt rules.
module tb_halt_dump_controller;
  localparam int          NUM_REGS   = 32;
  localparam int          MEM_WORDS  = 4;
  localparam int          MAX_CYCLES = 64;
  localparam logic [31:0] MEM_BASE   = 32'h4000;

  typedef struct {
    logic [1:0]  tag;
    logic [31:0] data;
  } rec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b0;
  logic        start = 1'b0, c_start = 1'b0;
  logic [31:0] pc, c_pc, inst, c_inst;
  logic        cpu_stall, c_cpu_stall;
  logic [4:0]  rf_raddr, c_rf_raddr;
  logic [31:0] rf_rdata, c_rf_rdata, mem_raddr, c_mem_raddr, mem_rdata, c_mem_rdata;
  logic        out_valid, c_out_valid;
  logic        out_ready = 1'b1, c_out_ready = 1'b1;
  logic [1:0]  out_tag, c_out_tag, halt_cause, c_halt_cause;
  logic [31:0] out_data, c_out_data;
  logic        busy, c_busy, done, c_done;

  int n_checks = 0;
  int n_fail   = 0;

  // Environment: register file, data memory and a CPU that steps PC by 4 on unstalled edges.
  logic [31:0] rf_arr [NUM_REGS];
  logic [31:0] salt;
  logic [31:0] zero_pc = 32'hFFFF_FFF0;
  logic        cpu_load = 1'b0;
  logic [31:0] cpu_load_pc = '0;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ salt;
  endfunction

  assign rf_rdata    = rf_arr[rf_raddr];
  assign c_rf_rdata  = rf_arr[c_rf_raddr];
  assign mem_rdata   = mem_val(mem_raddr);
  assign c_mem_rdata = mem_val(c_mem_raddr);
  assign inst        = (pc == zero_pc)   ? 32'h0 : 32'h0000_0013;
  assign c_inst      = (c_pc == zero_pc) ? 32'h0 : 32'h0000_0013;

  always @(posedge clk) begin
    if (cpu_load) begin
      pc   <= cpu_load_pc;
      c_pc <= cpu_load_pc;
    end else begin
      if (!cpu_stall)   pc   <= pc + 32'd4;
      if (!c_cpu_stall) c_pc <= c_pc + 32'd4;
    end
  end

  halt_dump_controller u_dut (
    .clk(clk), .reset(reset), .start(start), .pc(pc), .inst(inst),
    .cpu_stall(cpu_stall), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .out_valid(out_valid),
    .out_ready(out_ready), .out_tag(out_tag), .out_data(out_data),
    .halt_cause(halt_cause), .busy(busy), .done(done)
  );

  halt_dump_controller #(.TRACE_EN(1'b0), .MEM_WORDS(0)) u_cfg (
    .clk(clk), .reset(reset), .start(c_start), .pc(c_pc), .inst(c_inst),
    .cpu_stall(c_cpu_stall), .rf_raddr(c_rf_raddr), .rf_rdata(c_rf_rdata),
    .mem_raddr(c_mem_raddr), .mem_rdata(c_mem_rdata), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .out_tag(c_out_tag), .out_data(c_out_data),
    .halt_cause(c_halt_cause), .busy(c_busy), .done(c_done)
  );

  // Monitor: records are sampled mid-cycle, where valid/ready are settled.
  rec_t got[$], c_got[$];
  int   got_base = 0, c_base = 0;
  int   stall_seen = 0, stall_bad = 0;

  always @(negedge clk) begin
    if (reset && out_valid && out_ready)     got.push_back('{tag: out_tag, data: out_data});
    if (reset && c_out_valid && c_out_ready) c_got.push_back('{tag: c_out_tag, data: c_out_data});
    if (reset && out_valid && out_tag == 2'd0) begin
      stall_seen++;
      if (cpu_stall !== !out_ready) stall_bad++;
    end
  end

  // Reference: the record list a run must produce, from the halt and dump rules.
  rec_t        exp_q[$];
  logic [1:0]  exp_cause;
  logic [31:0] exp_end_pc;

  task automatic build_exp(input logic [31:0] p0, input logic [31:0] zpc,
                           input bit trace, input int mwords);
    logic [31:0] p;
    int k = 0;
    exp_q.delete();
    forever begin
      p = p0 + 32'(4 * k);
      if (trace) exp_q.push_back('{tag: 2'd0, data: p});
      if (p == zpc)            begin exp_cause = 2'd1; break; end
      if (k == MAX_CYCLES - 1) begin exp_cause = 2'd2; break; end
      k++;
    end
    exp_end_pc = p + 32'd4;
    for (int i = 0; i < NUM_REGS; i++) exp_q.push_back('{tag: 2'd1, data: rf_arr[i]});
    for (int j = 0; j < mwords; j++) exp_q.push_back('{tag: 2'd2, data: mem_val(MEM_BASE + 32'(j))});
    exp_q.push_back('{tag: 2'd3, data: {30'd0, exp_cause}});
  endtask

  function automatic int first_diff(input rec_t a[$], input rec_t b[$]);
    int n = (a.size() < b.size()) ? a.size() : b.size();
    for (int i = 0; i < n; i++)
      if (a[i].tag !== b[i].tag || a[i].data !== b[i].data) return i;
    return (a.size() != b.size()) ? n : -1;
  endfunction

  task automatic report_diff(input string name, input rec_t a[$], input int d);
    if (d < a.size() && d < exp_q.size())
      $display("FAIL %s: record %0d got tag=%0d data=%h, expected tag=%0d data=%h",
               name, d, a[d].tag, a[d].data, exp_q[d].tag, exp_q[d].data);
    else
      $display("FAIL %s: got %0d records, expected %0d", name, a.size(), exp_q.size());
  endtask

  // Loads the CPU, pulses start and handshakes with the chosen ready pattern
  // (0 always, 1 toggling, 2 random) until done or an optional REG index.
  task automatic drive_run(input bit cfg, input logic [31:0] p0, input logic [31:0] zpc,
                           input int mode, input int stop_reg, output bit finished);
    logic r;
    cpu_load_pc = p0; zero_pc = zpc; cpu_load = 1'b1;
    @(posedge clk); #1;
    cpu_load = 1'b0;
    got_base = got.size(); c_base = c_got.size();
    if (cfg) c_start = 1'b1; else start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; c_start = 1'b0;
    finished = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      r = (mode == 0) ? 1'b1 : (mode == 1) ? (i % 2 == 0) : 1'($urandom_range(0, 1));
      out_ready = r; c_out_ready = r;
      @(posedge clk); #1;
      if (stop_reg >= 0 && out_valid && out_tag == 2'd1 && rf_raddr == 5'(stop_reg)) begin
        finished = 1'b1; break;
      end
      if (cfg ? c_done : done) begin finished = 1'b1; break; end
    end
    out_ready = 1'b1; c_out_ready = 1'b1;
  endtask

  task automatic test_reset;
    logic [31:0] obs [9];
    logic [31:0] want [9] = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
    string nm [9] = '{"cpu_stall", "out_valid", "out_tag", "out_data", "rf_raddr",
                      "mem_raddr", "halt_cause", "busy", "done"};
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    obs = '{32'(cpu_stall), 32'(out_valid), 32'(out_tag), out_data, 32'(rf_raddr),
            mem_raddr, 32'(halt_cause), 32'(busy), 32'(done)};
    for (int i = 0; i < 9; i++) begin
      n_checks++;
      if (obs[i] !== want[i]) begin
        n_fail++;
        $display("FAIL reset_%s: got %h, expected %h", nm[i], obs[i], want[i]);
      end
    end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_run(input string name, input bit cfg, input logic [31:0] p0,
                          input logic [31:0] zpc, input int mode);
    bit fin;
    int d;
    drive_run(cfg, p0, zpc, mode, -1, fin);
    build_exp(p0, zpc, !cfg, cfg ? 0 : MEM_WORDS);
    n_checks++;
    if (!fin) begin n_fail++; $display("FAIL %s_timeout: done not seen, expected done=1", name); end
    d = cfg ? first_diff(c_got[c_base:$], exp_q) : first_diff(got[got_base:$], exp_q);
    n_checks++;
    if (d >= 0) begin n_fail++; report_diff(name, cfg ? c_got[c_base:$] : got[got_base:$], d); end
    n_checks++;
    if ((cfg ? c_halt_cause : halt_cause) !== exp_cause) begin
      n_fail++;
      $display("FAIL %s_cause: got %0d, expected %0d", name, cfg ? c_halt_cause : halt_cause, exp_cause);
    end
    n_checks++;
    if ((cfg ? c_pc : pc) !== exp_end_pc) begin
      n_fail++;
      $display("FAIL %s_frozen_pc: got %h, expected %h", name, cfg ? c_pc : pc, exp_end_pc);
    end
    n_checks++;
    if ((cfg ? {c_done, c_cpu_stall, c_out_valid, c_busy} : {done, cpu_stall, out_valid, busy}) !== 4'b1100) begin
      n_fail++;
      $display("FAIL %s_done_state: got done/stall/valid/busy=%b, expected 1100", name,
               cfg ? {c_done, c_cpu_stall, c_out_valid, c_busy} : {done, cpu_stall, out_valid, busy});
    end
  endtask

  task automatic test_zero_inst;   test_run("zero_inst", 1'b0, 32'h0, 32'h14, 0); endtask
  task automatic test_timeout;     test_run("timeout", 1'b0, 32'h100, 32'hFFFF_FFF0, 0); endtask
  task automatic test_simultaneous; test_run("simultaneous", 1'b0, 32'h800, 32'h800 + 32'd252, 0); endtask
  task automatic test_config_edge; test_run("config_edge", 1'b1, 32'h40, 32'h4C, 0); endtask

  task automatic test_backpressure;
    int seen0 = stall_seen, bad0 = stall_bad;
    test_run("bp_toggle", 1'b0, 32'h0, 32'h14, 1);
    test_run("bp_random", 1'b0, 32'h200, 32'h200 + 32'(4 * $urandom_range(3, 20)), 2);
    n_checks++;
    if (stall_bad != bad0) begin
      n_fail++;
      $display("FAIL bp_stall: %0d trace cycles with cpu_stall != !out_ready, expected 0", stall_bad - bad0);
    end
    n_checks++;
    if (stall_seen - seen0 < 12) begin
      n_fail++;
      $display("FAIL bp_trace_cycles: got %0d trace cycles, expected at least 12", stall_seen - seen0);
    end
  endtask

  task automatic test_reset_mid_dump;
    bit fin;
    int d;
    logic [31:0] obs [9];
    logic [31:0] want [9] = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
    rec_t pre[$];
    drive_run(1'b0, 32'h0, 32'h8, 0, 10, fin);
    n_checks++;
    if (!fin || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reach_reg10: reached=%0d busy=%0d, expected 1 1", fin, busy);
    end
    reset = 1'b0;
    #1;
    obs = '{32'(cpu_stall), 32'(out_valid), 32'(out_tag), out_data, 32'(rf_raddr),
            mem_raddr, 32'(halt_cause), 32'(busy), 32'(done)};
    for (int i = 0; i < 9; i++) begin
      n_checks++;
      if (obs[i] !== want[i]) begin
        n_fail++;
        $display("FAIL mid_reset_out%0d: got %h, expected %h", i, obs[i], want[i]);
      end
    end
    repeat (3) @(posedge clk);
    #1;
    build_exp(32'h0, 32'h8, 1'b1, MEM_WORDS);
    pre = exp_q[0:12];
    exp_q = pre;
    d = first_diff(got[got_base:$], exp_q);
    n_checks++;
    if (d >= 0) begin n_fail++; report_diff("mid_partial", got[got_base:$], d); end
    reset = 1'b1;
    @(posedge clk); #1;
    test_run("after_reset", 1'b0, 32'h300, 32'h31C, 0);
  endtask

  initial begin
    salt = $urandom;
    for (int i = 0; i < NUM_REGS; i++) rf_arr[i] = $urandom;
    rf_arr[11] = 32'd123;
    rf_arr[12] = 32'd100;
    rf_arr[13] = 32'd268501000;
    rf_arr[14] = 32'd268501004;
    rf_arr[15] = 32'd100000;
    test_reset();
    test_zero_inst();
    test_timeout();
    test_simultaneous();
    test_backpressure();
    test_config_edge();
    test_reset_mid_dump();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
